// File: rtl/tp_pkg.sv
// Shared definitions for the two-phase dual-rail result path.
//   RAIL_NUM        rails per dual-rail bit
//   RAIL0 / RAIL1   rail indices inside a bit; a RAIL1 transition encodes a logic 1
//   tp_sink_state_t result-sink FSM states
package tp_pkg;

    localparam int unsigned RAIL_NUM = 2;
    localparam int unsigned RAIL0    = 0;
    localparam int unsigned RAIL1    = 1;

    typedef enum logic [1:0] {
        StWait   = 2'd0,
        StSettle = 2'd1,
        StHold   = 2'd2,
        StErr    = 2'd3
    } tp_sink_state_t;

endpackage

// File: rtl/tp_result_sink_if.sv
// Bundle between an upstream dual-rail adder, the result sink and its binary consumer.
//   s, c_out   dual-rail sum and carry from the adder
//   ack_o      two-phase acknowledge back to the adder
//   res_*      binary result handshake toward the consumer
//   err        sticky protocol-violation flag
// Modports: master = the environment (adder + consumer), slave = the sink.
interface tp_result_sink_if
    import tp_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) ();

    logic [WIDTH-1:0][RAIL_NUM-1:0] s;
    logic [RAIL_NUM-1:0]            c_out;
    logic                           ack_o;
    logic                           res_valid;
    logic                           res_ready;
    logic [WIDTH:0]                 res_data;
    logic                           err;

    modport master (
        output s, c_out, res_ready,
        input  ack_o, res_valid, res_data, err
    );

    modport slave (
        input  s, c_out, res_ready,
        output ack_o, res_valid, res_data, err
    );

endinterface

// File: rtl/sync_vec.sv
// Multi-flop synchronizer for a vector with an asynchronous active-high reset.
//   clk, rst   clock and reset (reset loads every stage with INIT_VAL)
//   d          asynchronous input vector
//   q          synchronized output, STAGES clocks behind d
module sync_vec #(
    parameter int unsigned       WIDTH    = 1,
    parameter int unsigned       STAGES   = 2,
    parameter logic [WIDTH-1:0]  INIT_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_vec: STAGES must be at least 2");
    end

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= {STAGES{INIT_VAL}};
        end else begin
            stage_q <= {stage_q[STAGES-2:0], d};
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/tp_result_sink.sv
// Converts a two-phase dual-rail {carry, sum} token into a binary valid/ready result and
// returns a two-phase acknowledge once the consumer has taken it.
//   clk, rst   single clock, asynchronous active-high reset
//   bus.s      dual-rail sum      bus.c_out  dual-rail carry
//   bus.ack_o  toggles once per consumed token
//   bus.res_valid / res_ready / res_data   binary {carry, sum} result handshake
//   bus.err    sticky: some bit saw both rails transition; cleared only by rst
module tp_result_sink
    import tp_pkg::*;
#(
    parameter string                      ENC         = "TP",
    parameter int unsigned                WIDTH       = 1,
    parameter int unsigned                SYNC_STAGES = 2,
    parameter logic [2*(WIDTH+1)-1:0]     INIT_REF    = '0,
    parameter bit                         INIT_ACK    = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    tp_result_sink_if.slave bus
);

    localparam int unsigned NBITS = WIDTH + 1;
    localparam int unsigned RW    = RAIL_NUM * NBITS;

    if (ENC != "TP") begin : g_bad_enc
        $error("tp_result_sink: only the two-phase encoding \"TP\" is supported");
    end

    logic [RW-1:0] raw, cur, prev_q, ref_q, ref_d;
    logic [NBITS-1:0][RAIL_NUM-1:0] tog;
    logic [NBITS-1:0] complete, both, bit_val;
    logic all_complete, any_both, stable;

    tp_sink_state_t state_q, state_d;
    logic           ack_q, ack_d;
    logic           valid_q, valid_d;
    logic [WIDTH:0] data_q, data_d;
    logic           err_q, err_d;

    assign raw = {bus.c_out, bus.s};

    sync_vec #(
        .WIDTH    (RW),
        .STAGES   (SYNC_STAGES),
        .INIT_VAL (INIT_REF)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (raw),
        .q   (cur)
    );

    // Any rail transition relative to the last consumed level is data; the
    // direction (rise or return-to-level) does not matter.
    assign tog = cur ^ ref_q;

    always_comb begin
        complete = '0;
        both     = '0;
        bit_val  = '0;
        for (int unsigned j = 0; j < NBITS; j++) begin
            complete[j] = tog[j][RAIL1] ^ tog[j][RAIL0];
            both[j]     = tog[j][RAIL1] & tog[j][RAIL0];
            bit_val[j]  = tog[j][RAIL1];
        end
    end

    assign all_complete = &complete;
    assign any_both     = |both;
    // One extra quiet cycle guards against capturing a word that is still moving.
    assign stable       = (cur == prev_q);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        ack_d   = ack_q;
        valid_d = valid_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            StWait: begin
                if (any_both) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else if (all_complete) begin
                    state_d = StSettle;
                end
            end
            StSettle: begin
                if (any_both) begin
                    err_d   = 1'b1;
                    state_d = StErr;
                end else if (all_complete && stable) begin
                    data_d  = bit_val;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // Rails are ignored here; the new reference is whatever the
                // adder is showing at the moment the result is consumed.
                if (valid_q && bus.res_ready) begin
                    ref_d   = cur;
                    ack_d   = ~ack_q;
                    valid_d = 1'b0;
                    state_d = StWait;
                end
            end
            StErr: begin
                err_d   = 1'b1;
                valid_d = 1'b0;
            end
            default: begin
                err_d   = 1'b1;
                valid_d = 1'b0;
                state_d = StErr;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StWait;
            ref_q   <= INIT_REF;
            prev_q  <= INIT_REF;
            ack_q   <= INIT_ACK;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            prev_q  <= cur;
            ack_q   <= ack_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign bus.ack_o     = ack_q;
    assign bus.res_valid = valid_q;
    assign bus.res_data  = data_q;
    assign bus.err       = err_q;

endmodule

// File: doc/tp_result_sink.md
TP_RESULT_SINK -- requirements
Module: tp_result_sink

Interface
REQ-001 SHALL take parameter ENC, default "TP"; the two-phase (transition) dual-rail encoding is the only value supported.
REQ-002 SHALL take parameter WIDTH, default 1; this is the sum width, and the captured word is WIDTH+1 bits including the carry.
REQ-003 SHALL take parameter SYNC_STAGES, default 2, minimum 2; this is the number of flops in the input synchronizer.
REQ-004 SHALL take parameter INIT_REF, default 0, width 2*(WIDTH+1); this is the rail-level reference after reset, matching adder INIT values.
REQ-005 SHALL take parameter INIT_ACK, default 0; this is the ack_o level after reset.
REQ-006 SHALL have port clk, input, width 1: the single clock.
REQ-007 SHALL have port rst, input, width 1: reset, asynchronous and active-high.
REQ-008 SHALL have port s, input, [WIDTH-1:0][RAIL_NUM-1:0]: the dual-rail sum from the upstream adder.
REQ-009 SHALL have port c_out, input, [RAIL_NUM-1:0]: the dual-rail carry from the upstream adder.
REQ-010 SHALL have port ack_o, output, width 1: the two-phase acknowledge and the adder's ack_i; it toggles once per consumed token.
REQ-011 SHALL have port res_valid, output, width 1: the binary result is valid.
REQ-012 SHALL have port res_ready, input, width 1: the consumer accepts the result.
REQ-013 SHALL have port res_data, output, [WIDTH:0]: the binary result {carry, sum}.
REQ-014 SHALL have port err, output, width 1: a sticky protocol-violation flag.

Function
REQ-015 SHALL pass {c_out, s} through a SYNC_STAGES synchronizer; all decisions use the synchronized sample "cur".
REQ-016 SHALL define per bit: toggled = cur XOR ref; a bit is complete when exactly one rail toggled; the bit value is the rail-1 toggle.
REQ-017 SHALL implement FSM states WAIT, SETTLE, HOLD and ERR.
REQ-018 In WAIT, the FSM SHALL go to SETTLE when all WIDTH+1 bits are complete; partial completion SHALL stay in WAIT.
REQ-019 In SETTLE, if cur equals the previous cycle's cur and all bits are complete, the FSM SHALL latch res_data, set res_valid and go to HOLD; otherwise it SHALL stay in SETTLE.
REQ-020 In WAIT or SETTLE, any bit with both rails toggled SHALL set err and go to ERR.
REQ-021 In HOLD, res_valid and res_data SHALL be held stable, and rail activity SHALL be ignored.
REQ-022 In HOLD, on res_valid && res_ready at a clock edge, the block SHALL load ref<=cur, toggle ack_o, clear res_valid and go to WAIT, all in that same edge.
REQ-023 ERR SHALL be terminal until rst: err=1, res_valid=0, ack_o frozen.
REQ-024 Latency SHALL be SYNC_STAGES+2 clocks from the last rail transition to res_valid=1.
REQ-025 With res_ready held high, the result SHALL be accepted one clock after res_valid rises; the minimum token period is SYNC_STAGES+3 clocks plus upstream delay.
REQ-026 The rail return-to-level phase SHALL be treated identically to a rising phase, since any transition is data.

Reset
REQ-027 rst SHALL asynchronously force: state=WAIT, ref=INIT_REF, synchronizer flops=INIT_REF, ack_o=INIT_ACK, res_valid=0, res_data=0, err=0.
REQ-028 Reset mid-operation, including in HOLD or ERR, SHALL discard any pending token with no ack_o toggle.
REQ-029 Release of rst SHALL be synchronous-safe: no state change on the release edge itself.

Structure
REQ-030 Shared package tp_pkg SHALL hold RAIL_NUM=2, the RAIL0/RAIL1 index constants and the state enum tp_sink_state_t.
REQ-031 The synchronizer SHALL be the sub-module sync_vec (width, stages, init value, async reset).
REQ-032 There SHALL be no clock gating and no combinational path from inputs to outputs.

Verification
REQ-033 (WIDTH=4, INIT_REF=0) Assert rst -> ack_o=0, res_valid=0, res_data=0, err=0 immediately.
REQ-034 Toggle rail1 of bits 0 and 2 and the carry, and rail0 of bits 1 and 3 -> res_valid after 4 clocks, res_data=5'b10101; res_ready=1 -> ack_o=1 the next clock and res_valid=0.
REQ-035 Toggle one bit per clock over 5 clocks -> no res_valid before the 5th toggle plus 4 clocks; data correct. A second token that returns the rails to level 0 gives a correct value and ack_o back to 0.
REQ-036 Hold res_ready=0 for 10 clocks in HOLD and change s -> res_data and res_valid stable, ack_o unchanged, no err.
REQ-037 Toggle both rails of bit 1 -> err=1 sticky, res_valid never asserted, ack_o unchanged until rst.
REQ-038 Assert rst while in HOLD -> res_valid=0 and ack_o=INIT_ACK asynchronously; the next token is captured correctly after release.
